tcam_lookup_engine: RTL and testbench

//  Parametrised behavioural ternary CAM for the monitoring packet filter. It replaces the

---
 rtl/tcam_lookup_engine_if.sv | 34 +++
 rtl/tcam_lookup_engine.sv | 137 +++++++++++++
 tb/tb_tcam_lookup_engine.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tcam_lookup_engine_if.sv
// Lookup/maintenance bus of the packet-filter TCAM: rule-table writes, bulk clear, keys and results.
// Master drives writes and keys; slave is the TCAM engine.
interface tcam_lookup_engine_if #(
    parameter int C_TCAM_ADDR_WIDTH = 4,
    parameter int C_TCAM_DATA_WIDTH = 16
);
    logic                         WE;
    logic [C_TCAM_ADDR_WIDTH-1:0] WR_ADDR;
    logic                         WR_VALID;
    logic [C_TCAM_DATA_WIDTH-1:0] DIN;
    logic [C_TCAM_DATA_WIDTH-1:0] DATA_MASK;
    logic                         CLR;
    logic                         BUSY;
    logic                         WR_DROP;
    logic                         CMP_VALID;
    logic [C_TCAM_DATA_WIDTH-1:0] CMP_DIN;
    logic [C_TCAM_DATA_WIDTH-1:0] CMP_DATA_MASK;
    logic                         MATCH_VALID;
    logic                         MATCH;
    logic [C_TCAM_ADDR_WIDTH-1:0] MATCH_ADDR;
    logic                         MULTIPLE_MATCH;

    modport master (
        output WE, WR_ADDR, WR_VALID, DIN, DATA_MASK, CLR,
        output CMP_VALID, CMP_DIN, CMP_DATA_MASK,
        input  BUSY, WR_DROP, MATCH_VALID, MATCH, MATCH_ADDR, MULTIPLE_MATCH
    );

    modport slave (
        input  WE, WR_ADDR, WR_VALID, DIN, DATA_MASK, CLR,
        input  CMP_VALID, CMP_DIN, CMP_DATA_MASK,
        output BUSY, WR_DROP, MATCH_VALID, MATCH, MATCH_ADDR, MULTIPLE_MATCH
    );
endinterface

// File: rtl/tcam_lookup_engine.sv
// Ternary CAM with per-entry valid bits, invalidate, bulk-clear sweep and multi-match report.
// Latency: writes take effect at the strobe edge; lookups return exactly 2 cycles after CMP_VALID.
// Backpressure: none on lookups; writes and clears presented during the sweep are dropped (WR_DROP).
module tcam_lookup_engine #(
    parameter int C_TCAM_ADDR_WIDTH = 4,
    parameter int C_TCAM_DATA_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    tcam_lookup_engine_if.slave  bus
);
    localparam int AW    = C_TCAM_ADDR_WIDTH;
    localparam int DW    = C_TCAM_DATA_WIDTH;
    localparam int DEPTH = 1 << AW;

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            wr_en;
    logic            wr_drop_d, wr_drop_q;

    logic [DW-1:0]   val_q  [DEPTH];
    logic [DW-1:0]   mask_q [DEPTH];
    logic [DEPTH-1:0] vld_q;

    logic [DEPTH-1:0] hit_dat, hit_q;
    logic            s1_vld, s2_vld;
    logic            enc_hit, enc_multi;
    logic [AW-1:0]   enc_addr;
    logic            match_q, multi_q;
    logic [AW-1:0]   addr_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en     = 1'b0;
        wr_drop_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.CLR) begin
                    // clear wins over a coincident write
                    state_d   = ST_CLEAR;
                    cnt_d     = '0;
                    wr_drop_d = bus.WE;
                end else begin
                    wr_en = bus.WE;
                end
            end
            ST_CLEAR: begin
                cnt_d     = cnt_q + 1'b1;
                wr_drop_d = bus.WE;
                if (cnt_q == AW'(DEPTH - 1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            vld_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            vld_q[cnt_q] <= 1'b0;
        end else if (wr_en) begin
            vld_q[bus.WR_ADDR] <= bus.WR_VALID;
        end
    end

    // Entry contents are qualified by vld_q, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            val_q[bus.WR_ADDR]  <= bus.DIN;
            mask_q[bus.WR_ADDR] <= bus.DATA_MASK;
        end
    end

    always_comb begin
        hit_dat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_dat[i] = vld_q[i] &&
                         (&(mask_q[i] | bus.CMP_DATA_MASK | ~(val_q[i] ^ bus.CMP_DIN)));
        end
        if (state_q == ST_CLEAR) hit_dat = '0;
    end

    always_comb begin
        enc_hit   = 1'b0;
        enc_multi = 1'b0;
        enc_addr  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (hit_q[i]) begin
                if (enc_hit) enc_multi = 1'b1;
                else         enc_addr  = AW'(i);
                enc_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            s1_vld  <= 1'b0;
            hit_q   <= '0;
            s2_vld  <= 1'b0;
            match_q <= 1'b0;
            addr_q  <= '0;
            multi_q <= 1'b0;
        end else begin
            s1_vld <= bus.CMP_VALID;
            hit_q  <= hit_dat;
            s2_vld <= s1_vld;
            if (s1_vld) begin
                match_q <= enc_hit;
                addr_q  <= enc_addr;
                multi_q <= enc_multi;
            end
        end
    end

    assign bus.BUSY           = (state_q == ST_CLEAR);
    assign bus.WR_DROP        = wr_drop_q;
    assign bus.MATCH_VALID    = s2_vld;
    assign bus.MATCH          = match_q;
    assign bus.MATCH_ADDR     = addr_q;
    assign bus.MULTIPLE_MATCH = multi_q;
endmodule

// File: tb/tb_tcam_lookup_engine.sv
// Directed and randomized checks of tcam_lookup_engine against a table-level reference model.
module tb_tcam_lookup_engine;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic CLK    = 1'b0;
    logic RESETN = 1'b0;

    tcam_lookup_engine_if #(.C_TCAM_ADDR_WIDTH(AW), .C_TCAM_DATA_WIDTH(DW)) bus ();

    tcam_lookup_engine #(.C_TCAM_ADDR_WIDTH(AW), .C_TCAM_DATA_WIDTH(DW)) dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: table contents, sweep progress and the two lookup stages.
    bit          m_vld [DEPTH];
    logic [15:0] m_val [DEPTH];
    logic [15:0] m_msk [DEPTH];
    bit          m_busy;
    int          m_cnt;
    bit          m_drop;
    bit          s1_vld, s1_m, s1_multi;
    int          s1_addr;
    bit          o_vld, o_m, o_multi;
    int          o_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
        m_busy = 0; m_cnt = 0; m_drop = 0;
        s1_vld = 0; s1_m = 0; s1_multi = 0; s1_addr = 0;
        o_vld = 0; o_m = 0; o_multi = 0; o_addr = 0;
    endtask

    // Lowest matching valid entry and number of matches, bits compared only where neither mask is set.
    task automatic ref_lookup(input logic [15:0] key, input logic [15:0] kmask,
                              output bit m, output int addr, output bit multi);
        int n = 0;
        addr = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_vld[i] && (((m_val[i] ^ key) & ~(m_msk[i] | kmask)) == 16'h0)) begin
                if (n == 0) addr = i;
                n++;
            end
        end
        m     = (n > 0);
        multi = (n >= 2);
    endtask

    task automatic model_edge();
        bit nm, nmu;
        int na;
        ref_lookup(bus.CMP_DIN, bus.CMP_DATA_MASK, nm, na, nmu);
        if (m_busy) begin nm = 0; na = 0; nmu = 0; end
        o_vld = s1_vld;
        if (s1_vld) begin o_m = s1_m; o_addr = s1_addr; o_multi = s1_multi; end
        s1_vld = bus.CMP_VALID; s1_m = nm; s1_addr = na; s1_multi = nmu;
        m_drop = bus.WE && (m_busy || bus.CLR);
        if (m_busy) begin
            m_vld[m_cnt] = 1'b0;
            m_cnt++;
            if (m_cnt == DEPTH) m_busy = 0;
        end else if (bus.CLR) begin
            m_busy = 1; m_cnt = 0;
        end else if (bus.WE) begin
            m_vld[bus.WR_ADDR] = bus.WR_VALID;
            m_val[bus.WR_ADDR] = bus.DIN;
            m_msk[bus.WR_ADDR] = bus.DATA_MASK;
        end
    endtask

    task automatic check_all();
        chk("busy",     32'(bus.BUSY),           32'(m_busy));
        chk("wr_drop",  32'(bus.WR_DROP),        32'(m_drop));
        chk("mvalid",   32'(bus.MATCH_VALID),    32'(o_vld));
        chk("match",    32'(bus.MATCH),          32'(o_m));
        chk("addr",     32'(bus.MATCH_ADDR),     32'(o_addr));
        chk("multi",    32'(bus.MULTIPLE_MATCH), 32'(o_multi));
    endtask

    task automatic tick();
        model_edge();
        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic wr(input logic [3:0] addr, input logic valid, input logic [15:0] din,
                      input logic [15:0] mask);
        bus.WE = 1'b1; bus.WR_ADDR = addr; bus.WR_VALID = valid;
        bus.DIN = din; bus.DATA_MASK = mask;
        tick();
        bus.WE = 1'b0;
    endtask

    task automatic lookup(input logic [15:0] key, input logic [15:0] mask);
        bus.CMP_VALID = 1'b1; bus.CMP_DIN = key; bus.CMP_DATA_MASK = mask;
        tick();
        bus.CMP_VALID = 1'b0;
        tick();
    endtask

    task automatic expect_res(input string tag, input logic m, input logic [3:0] a, input logic mu);
        chk({tag, "_mvalid"}, 32'(bus.MATCH_VALID),    32'd1);
        chk({tag, "_match"},  32'(bus.MATCH),          32'(m));
        chk({tag, "_addr"},   32'(bus.MATCH_ADDR),     32'(a));
        chk({tag, "_multi"},  32'(bus.MULTIPLE_MATCH), 32'(mu));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        int busy_n;
        bit drop_seen;
        bus.WE = 0; bus.WR_ADDR = '0; bus.WR_VALID = 0; bus.DIN = '0; bus.DATA_MASK = '0;
        bus.CLR = 0; bus.CMP_VALID = 0; bus.CMP_DIN = '0; bus.CMP_DATA_MASK = '0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy",  32'(bus.BUSY),           32'd0);
        chk("rst_mv",    32'(bus.MATCH_VALID),    32'd0);
        chk("rst_match", 32'(bus.MATCH),          32'd0);
        chk("rst_addr",  32'(bus.MATCH_ADDR),     32'd0);
        chk("rst_multi", 32'(bus.MULTIPLE_MATCH), 32'd0);
        chk("rst_drop",  32'(bus.WR_DROP),        32'd0);
        RESETN = 1'b1;

        // Empty table misses
        lookup(16'h1234, 16'h0000);
        expect_res("t1", 1'b0, 4'd0, 1'b0);

        // Masked entry
        wr(4'd3, 1'b1, 16'h12F0, 16'h000F);
        lookup(16'h12F7, 16'h0000);
        expect_res("t2_hit", 1'b1, 4'd3, 1'b0);
        lookup(16'h13F7, 16'h0000);
        expect_res("t2_miss", 1'b0, 4'd0, 1'b0);

        // Multiple match, then invalidate the lower one
        wr(4'd5, 1'b1, 16'hAAAA, 16'h0000);
        wr(4'd9, 1'b1, 16'hAAAA, 16'h0000);
        lookup(16'hAAAA, 16'h0000);
        expect_res("t3_multi", 1'b1, 4'd5, 1'b1);
        wr(4'd5, 1'b0, 16'h0000, 16'h0000);
        lookup(16'hAAAA, 16'h0000);
        expect_res("t3_inval", 1'b1, 4'd9, 1'b0);

        // Same-cycle write and lookup sees the old entry
        bus.WE = 1'b1; bus.WR_ADDR = 4'd2; bus.WR_VALID = 1'b1;
        bus.DIN = 16'h0F0F; bus.DATA_MASK = 16'h0000;
        bus.CMP_VALID = 1'b1; bus.CMP_DIN = 16'h0F0F; bus.CMP_DATA_MASK = 16'h0000;
        tick();
        bus.WE = 1'b0;
        tick();
        expect_res("t4_same", 1'b0, 4'd0, 1'b0);
        bus.CMP_VALID = 1'b0;
        tick();
        expect_res("t4_next", 1'b1, 4'd2, 1'b0);

        // Fill, then bulk clear with a coincident write
        for (int i = 0; i < DEPTH; i++) wr(4'(i), 1'b1, 16'h1000 + 16'(i), 16'h0000);
        lookup(16'h1003, 16'h0000);
        expect_res("t5_full", 1'b1, 4'd3, 1'b0);
        bus.CLR = 1'b1; bus.WE = 1'b1; bus.WR_ADDR = 4'd0; bus.DIN = 16'hBEEF; bus.DATA_MASK = 16'h0;
        tick();
        bus.CLR = 1'b0; bus.WE = 1'b0;
        chk("t5_drop_clr", 32'(bus.WR_DROP), 32'd1);
        busy_n = 0;
        drop_seen = 0;
        bus.CMP_VALID = 1'b1; bus.CMP_DIN = 16'h1003; bus.CMP_DATA_MASK = 16'h0000;
        for (int c = 0; c < 40; c++) begin
            if (!bus.BUSY) break;
            bus.WE = (c == 5); bus.WR_ADDR = 4'd4; bus.WR_VALID = 1'b1; bus.DIN = 16'h1004;
            bus.CLR = (c == 8);
            busy_n++;
            tick();
            if (c == 5) begin
                chk("t5_drop_busy", 32'(bus.WR_DROP), 32'd1);
                drop_seen = bus.WR_DROP;
            end
            if (bus.MATCH_VALID) chk("t5_sweep_miss", 32'(bus.MATCH), 32'd0);
        end
        bus.WE = 1'b0; bus.CLR = 1'b0; bus.CMP_VALID = 1'b0;
        chk("t5_busy_len", 32'(busy_n), 32'd16);
        chk("t5_drop_seen", 32'(drop_seen), 32'd1);
        tick();
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            lookup(16'h1000 + 16'(i), 16'h0000);
            expect_res("t5_after", 1'b0, 4'd0, 1'b0);
        end
        lookup(16'hBEEF, 16'h0000);
        expect_res("t5_beef", 1'b0, 4'd0, 1'b0);

        // Reset in the middle of a sweep
        wr(4'd7, 1'b1, 16'h5555, 16'h0000);
        lookup(16'h5555, 16'h0000);
        expect_res("t6_pre", 1'b1, 4'd7, 1'b0);
        bus.CLR = 1'b1;
        tick();
        bus.CLR = 1'b0;
        repeat (3) tick();
        RESETN = 1'b0;
        #1;
        chk("t6_busy",  32'(bus.BUSY),           32'd0);
        chk("t6_mv",    32'(bus.MATCH_VALID),    32'd0);
        chk("t6_match", 32'(bus.MATCH),          32'd0);
        chk("t6_addr",  32'(bus.MATCH_ADDR),     32'd0);
        chk("t6_multi", 32'(bus.MULTIPLE_MATCH), 32'd0);
        model_reset();
        @(posedge CLK);
        #1;
        RESETN = 1'b1;
        wr(4'd11, 1'b1, 16'h7777, 16'h0000);
        lookup(16'h7777, 16'h0000);
        expect_res("t6_post", 1'b1, 4'd11, 1'b0);
        lookup(16'h5555, 16'h0000);
        expect_res("t6_gone", 1'b0, 4'd0, 1'b0);

        // Randomized traffic over a small key space to force overlaps
        for (int k = 0; k < 400; k++) begin
            bus.WE            = ($urandom_range(0, 99) < 35);
            bus.WR_ADDR       = 4'($urandom_range(0, 15));
            bus.WR_VALID      = ($urandom_range(0, 9) != 0);
            bus.DIN           = {8'hC3, 5'b0, 3'($urandom_range(0, 7))};
            bus.DATA_MASK     = ($urandom_range(0, 3) == 0) ? 16'h0003 : 16'h0000;
            bus.CLR           = ($urandom_range(0, 59) == 0);
            bus.CMP_VALID     = ($urandom_range(0, 99) < 60);
            bus.CMP_DIN       = {8'hC3, 5'b0, 3'($urandom_range(0, 7))};
            bus.CMP_DATA_MASK = ($urandom_range(0, 4) == 0) ? 16'h0001 : 16'h0000;
            tick();
        end
        bus.WE = 1'b0; bus.CLR = 1'b0; bus.CMP_VALID = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
